run_launcher: RTL and testbench
===============================

# run_launcher

Host-side initiator for the core's `req`/`done` run handshake: the counterpart of the control unit that answers it. On one `start` pulse it launches NUM_PROGS programs back to back, one per `req` pulse. For each program it drives the program-select index, waits for the core to leave and then re-enter the done state, and reports the measured run length. It sits between the testbench/top-level and the core, replacing hand-driven `req` sequencing.

## Interface
Parameters:
- NUM_PROGS, 3, number of programs launched per `start`; must be ≥ 1
- REQ_LEN, 2, cycles `req` is held high per launch; must be ≥ 1
- CNT_W, 16, width of the run-length counter
- TIMEOUT, 4096, run-length limit in cycles; used only with `RUN_LAUNCHER_TIMEOUT_EN`

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  launch request; sampled only in IDLE or FINISH
- cpu_done  in  1  core `done`; high = core halted
- req  out  1  core `req`; drives PC reset and enables execution
- prog_sel  out  max(1,$clog2(NUM_PROGS))  index of the program being run
- busy  out  1  high in every state except IDLE and FINISH
- run_valid  out  1  one-cycle pulse when a program completes
- run_cycles  out  CNT_W  length of the completed run; valid while `run_valid` is high, held afterwards
- all_done  out  1  high in FINISH
- timed_out  out  1  sticky timeout flag; constant 0 without the macro

## Operation
- States: IDLE, REQ, WAIT_LOW, RUN, FINISH.
- Reset (`rst_n`=0 at a clock edge) puts every output at 0 and the state in IDLE:
  - req, busy, run_valid, all_done, timed_out = 0
  - prog_sel = 0, run_cycles = 0
- Reset mid-run deasserts `req` on the same edge. No completion is reported for the aborted run.
- IDLE or FINISH with `start`=1 goes to REQ:
  - prog_sel ← 0, timed_out ← 0, all_done ← 0
  - a down-counter is loaded with REQ_LEN.
- REQ:
  - `req`=1 for exactly REQ_LEN cycles; prog_sel stays stable.
  - When the count expires, `req` drops and the state moves to WAIT_LOW. The run counter clears to 0.
- WAIT_LOW:
  - Waits for `cpu_done`=0, i.e. the core accepted the launch, then moves to RUN.
  - The run counter increments every cycle in this state.
- RUN:
  - The run counter increments every cycle.
  - `cpu_done`=1 completes the program:
    - run_cycles ← counter value, pulse run_valid.
    - If prog_sel = NUM_PROGS-1, go to FINISH.
    - Otherwise prog_sel increments and the state moves to REQ with REQ_LEN reloaded.
- FINISH: all_done=1, busy=0. Holds until the next `start`.
- The run counter saturates at 2^CNT_W−1 and does not wrap.
- `start` is ignored while busy=1.
- `cpu_done`=1 while in REQ is ignored; the core holds done low only after `req` falls.

## Timing
- From `start` sampled high at edge N:
  - `req` is high for cycles N+1 … N+REQ_LEN.
  - busy rises at N+1.
- All outputs are registered; there is no combinational path from any input to any output.
- `cpu_done` already low in the first WAIT_LOW cycle: RUN is entered the next cycle.
- Run-length definition:
  - The counter counts cycles from the first cycle with `req`=0, up to and including the cycle in which `cpu_done`=1 is sampled in RUN.
  - `run_valid`/`run_cycles` appear the following cycle.
- Completion to the next program's `req` rise is 1 cycle; `run_valid` is high in that same cycle.
- Last program: all_done rises together with the final `run_valid`.
- NUM_PROGS=1: prog_sel is held at 0.

## Configuration
- `RUN_LAUNCHER_TIMEOUT_EN` defined:
  - If the run counter reaches TIMEOUT−1 in WAIT_LOW or RUN without a completion, timed_out ← 1 and the state goes to FINISH.
  - No `run_valid` pulse is issued for that run, and the remaining programs are skipped.
  - timed_out stays high until reset or the next `start`.
- Not defined: no timeout logic; timed_out is tied to 0; a hung core leaves the block in RUN indefinitely.

## Test plan
- Reset mid-RUN: rst_n=0 for one cycle → next cycle req=0, busy=0, prog_sel=0, all_done=0, run_valid=0, timed_out=0; state IDLE.
- NUM_PROGS=3, REQ_LEN=2; model core drops `cpu_done` 1 cycle after `req` falls and raises it after 10, 20 and 5 further cycles:
  - three `run_valid` pulses with prog_sel 0, 1, 2 in turn
  - run_cycles = 11, 21, 6
  - all_done rises with the third pulse.
- Per-launch `req` width and `start` while busy: `req` is high exactly 2 cycles per launch; a second `start` during RUN has no effect on state or prog_sel.
- `cpu_done` held high throughout REQ, then low in the first cycle after `req` falls: no early completion; the block passes WAIT_LOW→RUN in 1 cycle.
- With `RUN_LAUNCHER_TIMEOUT_EN`, TIMEOUT=50, core never raises done → timed_out=1 and all_done=1 after 50 counted cycles; no run_valid; a new `start` clears timed_out.
- CNT_W=4, run of 30 cycles, timeout disabled → run_cycles=15 (saturated).

Source files
------------

// File: rtl/run_launcher.sv
// Host-side launcher: sequences NUM_PROGS req/done runs per start and reports each run length.
// Optional run timeout is compiled in with `define RUN_LAUNCHER_TIMEOUT_EN.
module run_launcher #(
  parameter int NUM_PROGS = 3,
  parameter int REQ_LEN   = 2,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 4096,
  localparam int PW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int RW = $clog2(REQ_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cpu_done,
  output logic             req,
  output logic [PW-1:0]    prog_sel,
  output logic             busy,
  output logic             run_valid,
  output logic [CNT_W-1:0] run_cycles,
  output logic             all_done,
  output logic             timed_out
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_LOW, RUN, FINISH} state_t;

`ifdef RUN_LAUNCHER_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  state_t           state, state_nx;
  logic [RW-1:0]    req_cnt;
  logic [CNT_W-1:0] rc, rc_inc;
  logic             last, to_hit, launch;

  assign rc_inc = (rc == '1) ? rc : rc + 1'b1;
  assign last   = (prog_sel == PW'(NUM_PROGS - 1));
  // TIMEOUT is assumed to fit in the run counter
  assign to_hit = TO_EN && (rc == CNT_W'(TIMEOUT - 1));
  assign launch = ((state == IDLE) || (state == FINISH)) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FINISH: if (start) state_nx = REQ;
      REQ:          if (req_cnt == RW'(1)) state_nx = WAIT_LOW;
      WAIT_LOW: begin
        if (to_hit)         state_nx = FINISH;
        else if (!cpu_done) state_nx = RUN;
      end
      RUN: begin
        if (cpu_done)    state_nx = last ? FINISH : REQ;
        else if (to_hit) state_nx = FINISH;
      end
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req        <= 1'b0;
      prog_sel   <= '0;
      busy       <= 1'b0;
      run_valid  <= 1'b0;
      run_cycles <= '0;
      all_done   <= 1'b0;
      req_cnt    <= '0;
      rc         <= '0;
    end else begin
      run_valid <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            req      <= 1'b1;
            busy     <= 1'b1;
            prog_sel <= '0;
            all_done <= 1'b0;
            req_cnt  <= RW'(REQ_LEN);
          end
        end
        REQ: begin
          req_cnt <= req_cnt - 1'b1;
          if (req_cnt == RW'(1)) begin
            req <= 1'b0;
            rc  <= '0;
          end
        end
        WAIT_LOW: begin
          rc <= rc_inc;
          if (to_hit) begin
            busy     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        RUN: begin
          rc <= rc_inc;
          // the completing cycle itself is part of the run length
          if (cpu_done) begin
            run_valid  <= 1'b1;
            run_cycles <= rc_inc;
            if (last) begin
              busy     <= 1'b0;
              all_done <= 1'b1;
            end else begin
              prog_sel <= prog_sel + 1'b1;
              req      <= 1'b1;
              req_cnt  <= RW'(REQ_LEN);
            end
          end else if (to_hit) begin
            busy     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RUN_LAUNCHER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      timed_out <= 1'b0;
    else if (launch)
      timed_out <= 1'b0;
    else if (to_hit && ((state == WAIT_LOW) || ((state == RUN) && !cpu_done)))
      timed_out <= 1'b1;
  end
`else
  assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_run_launcher.sv
// Directed bench for run_launcher: three-program sequence, reset abort, counter saturation, optional timeout.
module tb_run_launcher;
  logic clk = 1'b0;
  logic rst_n, start, cpu_done;
  logic req, busy, run_valid, all_done, timed_out;
  logic [1:0]  prog_sel;
  logic [15:0] run_cycles;

  logic start2, done2;
  logic req2, busy2, run_valid2, all_done2, timed_out2;
  logic [0:0] prog_sel2;
  logic [3:0] run_cycles2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_launcher #(.NUM_PROGS(3), .REQ_LEN(2), .CNT_W(16), .TIMEOUT(4096)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_done(cpu_done), .req(req),
    .prog_sel(prog_sel), .busy(busy), .run_valid(run_valid), .run_cycles(run_cycles),
    .all_done(all_done), .timed_out(timed_out));

  run_launcher #(.NUM_PROGS(1), .REQ_LEN(1), .CNT_W(4), .TIMEOUT(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cpu_done(done2), .req(req2),
    .prog_sel(prog_sel2), .busy(busy2), .run_valid(run_valid2), .run_cycles(run_cycles2),
    .all_done(all_done2), .timed_out(timed_out2));

`ifdef RUN_LAUNCHER_TIMEOUT_EN
  logic start3, done3;
  logic req3, busy3, run_valid3, all_done3, timed_out3;
  logic [1:0]  prog_sel3;
  logic [15:0] run_cycles3;
  run_launcher #(.NUM_PROGS(3), .REQ_LEN(2), .CNT_W(16), .TIMEOUT(50)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .cpu_done(done3), .req(req3),
    .prog_sel(prog_sel3), .busy(busy3), .run_valid(run_valid3), .run_cycles(run_cycles3),
    .all_done(all_done3), .timed_out(timed_out3));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of the first req cycle; leaves at the negedge of the run_valid cycle.
  task automatic run_prog(input int k, input int exp_cycles, input int p, input logic is_last);
    int w = 0;
    while (req === 1'b1 && w < 20) begin
      chk("prog_sel_in_req", prog_sel, p);
      w++;
      @(negedge clk);
    end
    chk("req_width", w, 2);
    chk("busy_after_req", busy, 1);
    chk("no_early_done", run_valid, 0);
    cpu_done = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 4) begin
        chk("busy_ignores_start", busy, 1);
        chk("sel_ignores_start", prog_sel, p);
      end
    end
    start = 1'b0;
    cpu_done = 1'b1;
    @(negedge clk);
    chk("run_valid", run_valid, 1);
    chk("run_cycles", run_cycles, exp_cycles);
    chk("all_done", all_done, is_last);
    chk("req_next", req, !is_last);
    chk("busy_at_done", busy, !is_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0; start = 1'b0; cpu_done = 1'b1; start2 = 1'b0; done2 = 1'b1;
`ifdef RUN_LAUNCHER_TIMEOUT_EN
    start3 = 1'b0; done3 = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prog_sel", prog_sel, 0);
    chk("rst_run_valid", run_valid, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_timed_out", timed_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // three programs, done delays 10/20/5
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("req_rise", req, 1);
    run_prog(10, 11, 0, 1'b0);
    run_prog(20, 21, 1, 1'b0);
    run_prog(5, 6, 2, 1'b1);
    @(negedge clk);
    chk("run_valid_pulse", run_valid, 0);
    chk("finish_hold", all_done, 1);
    chk("finish_sel", prog_sel, 2);
    chk("no_timeout", timed_out, 0);

    // relaunch from FINISH, then abort with reset in RUN
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("relaunch_all_done", all_done, 0);
    chk("relaunch_sel", prog_sel, 0);
    chk("relaunch_req", req, 1);
    w = 0;
    while (req === 1'b1 && w < 20) begin w++; @(negedge clk); end
    chk("relaunch_req_width", w, 2);
    cpu_done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_req", req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sel", prog_sel, 0);
    chk("abort_all_done", all_done, 0);
    chk("abort_run_valid", run_valid, 0);
    chk("abort_timed_out", timed_out, 0);
    cpu_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_report", run_valid, 0);
    chk("abort_idle", busy, 0);

    // saturation on a 4-bit counter, single program
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    w = 0;
    while (req2 === 1'b1 && w < 20) begin w++; @(negedge clk); end
    chk("sat_req_width", w, 1);
    done2 = 1'b0;
    repeat (29) @(negedge clk);
    done2 = 1'b1;
    @(negedge clk);
    chk("sat_run_valid", run_valid2, 1);
    chk("sat_run_cycles", run_cycles2, 15);
    chk("sat_all_done", all_done2, 1);
    chk("sat_prog_sel", prog_sel2, 0);
    chk("sat_timed_out", timed_out2, 0);

`ifdef RUN_LAUNCHER_TIMEOUT_EN
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    w = 0;
    while (req3 === 1'b1 && w < 20) begin w++; @(negedge clk); end
    done3 = 1'b0;
    repeat (49) @(negedge clk);
    chk("to_not_yet", timed_out3, 0);
    @(negedge clk);
    chk("to_flag", timed_out3, 1);
    chk("to_all_done", all_done3, 1);
    chk("to_busy", busy3, 0);
    chk("to_no_valid", run_valid3, 0);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("to_cleared", timed_out3, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
